// File: rtl/sort_pkg.sv
// Shared types and pass schedule for the sequential 16-element bitonic sorter.
package sort_pkg;

  localparam int unsigned ELEM_N = 16;
  localparam int unsigned PASS_N = 10;

  typedef enum logic [1:0] {StIdle, StSort, StDone} state_t;

  // (k, j) per pass: merge size k, compare distance j
  localparam logic [4:0] PASS_K [PASS_N] = '{
    5'd2, 5'd4, 5'd4, 5'd8, 5'd8, 5'd8, 5'd16, 5'd16, 5'd16, 5'd16
  };
  localparam logic [4:0] PASS_J [PASS_N] = '{
    5'd1, 5'd2, 5'd1, 5'd4, 5'd2, 5'd1, 5'd8, 5'd4, 5'd2, 5'd1
  };

endpackage

// File: rtl/bitonic_cx_rank.sv
// One combinational rank of 8 compare-exchange units for a 16-element bitonic network.
module bitonic_cx_rank
  import sort_pkg::*;
#(
  parameter int unsigned ELEM_W = 8
) (
  input  logic [ELEM_N*ELEM_W-1:0] vec_i,
  input  logic [4:0]               k_i,
  input  logic [4:0]               j_i,
  input  logic                     descend_i,
  output logic [ELEM_N*ELEM_W-1:0] vec_o
);

  int                ptn;
  logic              up;
  logic [ELEM_W-1:0] a;
  logic [ELEM_W-1:0] b;

  // Pairs (i, i^j) are disjoint within a pass, so reading only vec_i is safe.
  always_comb begin
    vec_o = vec_i;
    ptn   = 0;
    up    = 1'b1;
    a     = '0;
    b     = '0;
    for (int i = 0; i < ELEM_N; i++) begin
      ptn = i ^ int'(j_i);
      up  = ((i & int'(k_i)) == 0) ^ descend_i;
      a   = vec_i[i*ELEM_W +: ELEM_W];
      b   = vec_i[ptn*ELEM_W +: ELEM_W];
      if (ptn > i && (up ? (a > b) : (a < b))) begin
        vec_o[i*ELEM_W +: ELEM_W]   = b;
        vec_o[ptn*ELEM_W +: ELEM_W] = a;
      end
    end
  end

endmodule

// File: rtl/sort_16x8b_bitonic_seq.sv
// Sequential bitonic sorter: 16 elements, one compare-exchange rank reused over 10 passes.
// Optional SORT_DIR_EN adds in_descend_i to select descending order per sort.
module sort_16x8b_bitonic_seq
  import sort_pkg::*;
#(
  parameter int unsigned ELEM_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ELEM_N*ELEM_W-1:0] data_in_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [ELEM_N*ELEM_W-1:0] data_out_o,
`ifdef SORT_DIR_EN
  input  logic                     in_descend_i,
`endif
  output logic                     busy_o
);

  state_t                   state_q, state_d;
  logic [3:0]               pass_q, pass_d;
  logic [ELEM_N*ELEM_W-1:0] vec_q, vec_d;
  logic                     descend_q, descend_d;
  logic                     descend_in;
  logic [ELEM_N*ELEM_W-1:0] rank_vec;

`ifdef SORT_DIR_EN
  assign descend_in = in_descend_i;
`else
  assign descend_in = 1'b0;
`endif

  bitonic_cx_rank #(
    .ELEM_W (ELEM_W)
  ) u_rank (
    .vec_i     (vec_q),
    .k_i       (PASS_K[pass_q]),
    .j_i       (PASS_J[pass_q]),
    .descend_i (descend_q),
    .vec_o     (rank_vec)
  );

  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    vec_d      = vec_q;
    descend_d  = descend_q;
    in_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          vec_d     = data_in_i;
          pass_d    = '0;
          descend_d = descend_in;
          state_d   = StSort;
        end
      end
      StSort: begin
        vec_d = rank_vec;
        if (pass_q == 4'(PASS_N - 1)) begin
          pass_d  = '0;
          state_d = StDone;
        end else begin
          pass_d = pass_q + 4'd1;
        end
      end
      StDone: begin
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          // Retire and reload on the same edge keeps back-to-back sorts bubble-free
          if (in_valid_i) begin
            vec_d     = data_in_i;
            pass_d    = '0;
            descend_d = descend_in;
            state_d   = StSort;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pass_q    <= '0;
      vec_q     <= '0;
      descend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      vec_q     <= vec_d;
      descend_q <= descend_d;
    end
  end

  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StSort);
  assign data_out_o  = vec_q;

endmodule
